// File: rtl/serial_subtractor.sv
// ============================================================================
// Module  : serial_subtractor
// Brief   : Bit-serial WIDTH-bit subtractor (a - b), LSB first, start/done
//           handshake. Optional two's-complement overflow output when the
//           macro SERIAL_SUBTRACTOR_OVF_EN is defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;

  logic             w_a0, w_b0, w_bit, w_br_next;
  logic [WIDTH-1:0] w_res_next;

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic a_msb_q, a_msb_d;
  logic b_msb_q, b_msb_d;
  logic ovf_q, ovf_d;
`endif

  // Full-subtractor cell on the current LSBs and the stored borrow.
  always_comb begin
    w_a0       = a_sr_q[0];
    w_b0       = b_sr_q[0];
    w_bit      = w_a0 ^ w_b0 ^ br_q;
    w_br_next  = (~w_a0 & w_b0) | (~(w_a0 ^ w_b0) & br_q);
    w_res_next = {w_bit, res_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    ovf_d   = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SHIFT;
          a_sr_d  = a;
          b_sr_d  = b;
          res_d   = '0;
          cnt_d   = '0;
          br_d    = 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
`endif
        end
      end
      S_SHIFT: begin
        a_sr_d = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d = {1'b0, b_sr_q[WIDTH-1:1]};
        res_d  = w_res_next;
        br_d   = w_br_next;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == C_LAST) begin
          state_d = S_DONE;
          diff_d  = w_res_next;
          bout_d  = w_br_next;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
          // The final cell output is the result MSB.
          ovf_d   = (a_msb_q != b_msb_q) && (w_bit != a_msb_q);
`endif
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
    end
  end

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

  assign busy = (state_q == S_SHIFT);
  assign done = (state_q == S_DONE);
  assign diff = diff_q;
  assign bout = bout_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// ============================================================================
// Module  : tb_serial_subtractor
// Brief   : Self-checking bench for serial_subtractor (WIDTH=8), with a
//           cycle-level behavioural model and directed literal vectors.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic         ovf;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit tb_end   = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a_in),
    .b    (b_in),
    .busy (busy),
    .done (done),
    .diff (diff),
    .bout (bout)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    .ovf  (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: time since acceptance decides busy/done; the result
  // is plain modular arithmetic on the operands seen at acceptance.
  int           m_since;
  logic [W-1:0] m_a, m_b;
  logic [W-1:0] m_sub;
  logic [W-1:0] e_diff;
  logic         e_bout;
  logic         e_ovf;

  assign m_sub = m_a - m_b;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_since <= -1;
      m_a     <= '0;
      m_b     <= '0;
      e_diff  <= '0;
      e_bout  <= 1'b0;
      e_ovf   <= 1'b0;
    end else if (m_since < 0) begin
      if (start) begin
        m_since <= 0;
        m_a     <= a_in;
        m_b     <= b_in;
      end
    end else if (m_since == W - 1) begin
      m_since <= W;
      e_diff  <= m_sub;
      e_bout  <= (m_a < m_b);
      e_ovf   <= (m_a[W-1] != m_b[W-1]) && (m_sub[W-1] != m_a[W-1]);
    end else if (m_since == W) begin
      m_since <= -1;
    end else begin
      m_since <= m_since + 1;
    end
  end

  always @(negedge clk) begin
    if (rst_n && !tb_end) begin
      check("model_busy", {31'd0, busy}, {31'd0, (m_since >= 0 && m_since < W)});
      check("model_done", {31'd0, done}, {31'd0, (m_since == W)});
      check("model_diff", {24'd0, diff}, {24'd0, e_diff});
      check("model_bout", {31'd0, bout}, {31'd0, e_bout});
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      check("model_ovf", {31'd0, ovf}, {31'd0, e_ovf});
`endif
    end
  end

  // Called just after the accept edge; counts edges until done and busy cycles.
  task automatic wait_done(output int edges, output int nbusy, output bit seen);
    edges = -1;
    nbusy = 0;
    seen  = 1'b0;
    for (int i = 1; i <= W + 6; i++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (done) begin
        seen  = 1'b1;
        edges = i - 1;
        break;
      end
    end
  endtask

  task automatic run_op(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] ed, input logic eb);
    int  edges, nbusy;
    bit  seen;
    @(posedge clk);
    #2;
    a_in  = av;
    b_in  = bv;
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    a_in  = W'($urandom);
    b_in  = W'($urandom);
    wait_done(edges, nbusy, seen);
    check({name, "_done_seen"}, {31'd0, seen}, 32'd1);
    check({name, "_latency"}, edges, W);
    check({name, "_busy_cycles"}, nbusy, W);
    check({name, "_diff"}, {24'd0, diff}, {24'd0, ed});
    check({name, "_bout"}, {31'd0, bout}, {31'd0, eb});
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    #1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_diff", {24'd0, diff}, 32'd0);
    check("reset_bout", {31'd0, bout}, 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    run_op("basic_5m3", 8'h05, 8'h03, 8'h02, 1'b0);
    run_op("basic_3m5", 8'h03, 8'h05, 8'hFE, 1'b1);
    run_op("zero_zero", 8'h00, 8'h00, 8'h00, 1'b0);
    run_op("ff_ff",     8'hFF, 8'hFF, 8'h00, 1'b0);
    run_op("zero_one",  8'h00, 8'h01, 8'hFF, 1'b1);

`ifdef SERIAL_SUBTRACTOR_OVF_EN
    run_op("ovf_80m01", 8'h80, 8'h01, 8'h7F, 1'b0);
    check("ovf_80m01_ovf", {31'd0, ovf}, 32'd1);
    run_op("ovf_7fmff", 8'h7F, 8'hFF, 8'h80, 1'b1);
    check("ovf_7fmff_ovf", {31'd0, ovf}, 32'd1);
    run_op("ovf_10m01", 8'h10, 8'h01, 8'h0F, 1'b0);
    check("ovf_10m01_ovf", {31'd0, ovf}, 32'd0);
`endif

    // Second start in the third SHIFT cycle must be ignored, not queued.
    begin
      int npulse;
      logic [W-1:0] got;
      npulse = 0;
      got    = '0;
      @(posedge clk);
      #2;
      a_in = 8'h30; b_in = 8'h12; start = 1'b1;
      @(posedge clk);
      #2 start = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      a_in = 8'h10; b_in = 8'h01; start = 1'b1;
      @(posedge clk);
      #2 start = 1'b0;
      for (int i = 0; i < 2 * W + 4; i++) begin
        @(negedge clk);
        if (done) begin
          npulse++;
          got = diff;
        end
      end
      check("busy_start_pulses", npulse, 1);
      check("busy_start_diff", {24'd0, got}, 32'h1E);
    end

    // Asynchronous reset in the fourth SHIFT cycle.
    @(posedge clk);
    #2;
    a_in = 8'h55; b_in = 8'h11; start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_diff", {24'd0, diff}, 32'd0);
    check("midrst_bout", {31'd0, bout}, 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    run_op("after_rst", 8'h20, 8'h0F, 8'h11, 1'b0);

    // start held high across three operations.
    begin
      logic [W-1:0] opa [3];
      logic [W-1:0] opb [3];
      logic [W-1:0] ed  [3];
      logic         eb  [3];
      int           tdone [3];
      bit           seen;
      opa = '{8'h40, 8'h09, 8'h81};
      opb = '{8'h05, 8'h0A, 8'h01};
      ed  = '{8'h3B, 8'hFF, 8'h80};
      eb  = '{1'b0, 1'b1, 1'b0};
      @(posedge clk);
      #2;
      a_in = opa[0]; b_in = opb[0]; start = 1'b1;
      for (int k = 0; k < 3; k++) begin
        seen = 1'b0;
        tdone[k] = 0;
        for (int i = 0; i < 2 * W + 6; i++) begin
          @(negedge clk);
          if (done) begin
            seen = 1'b1;
            tdone[k] = cyc;
            break;
          end
        end
        check("b2b_done_seen", {31'd0, seen}, 32'd1);
        check("b2b_diff", {24'd0, diff}, {24'd0, ed[k]});
        check("b2b_bout", {31'd0, bout}, {31'd0, eb[k]});
        if (k < 2) begin
          a_in = opa[k+1];
          b_in = opb[k+1];
        end else begin
          start = 1'b0;
        end
      end
      check("b2b_gap01", tdone[1] - tdone[0], W + 2);
      check("b2b_gap12", tdone[2] - tdone[1], W + 2);
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    tb_end = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule

`default_nettype wire
